// File: rtl/mips_boot_loader_if.sv
// Load-image stream between a boot host and mips_boot_loader.
// Handshake: a word transfers on a rising edge where valid && ready are both 1;
// the master holds sel/addr/data/last stable while valid is high and ready is low.
interface mips_boot_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LD_ADDR_W  = 10
) ();
  logic                  valid;
  logic                  ready;
  logic [1:0]            sel;
  logic [LD_ADDR_W-1:0]  addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, sel, addr, data, last, input ready);
  modport slave  (input valid, sel, addr, data, last, output ready);
endinterface

// File: rtl/mips_boot_loader.sv
// Boot sequencer for MIPS_core: holds the core in reset, zero-fills IMEM/DMEM/RF,
// loads an image from a valid/ready stream, then releases the core after a delay.
module mips_boot_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMEM_DEPTH     = 512,
  parameter int DMEM_DEPTH     = 1024,
  parameter int RF_DEPTH       = 32,
  parameter int LD_ADDR_W      = 10,
  parameter int RELEASE_CYCLES = 4,
  parameter int AUTO_START     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  mips_boot_loader_if.slave             ld,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]         imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]         dmem_wdata,
  output logic                          rf_we,
  output logic [$clog2(RF_DEPTH)-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic                          core_rst,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    state_dbg
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam int RF_AW   = $clog2(RF_DEPTH);
  localparam int MAXD_ID = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
  localparam int MAXD    = (MAXD_ID > RF_DEPTH) ? MAXD_ID : RF_DEPTH;
  localparam int CW      = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int HW      = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [HW-1:0]         hold_cnt, hold_cnt_n;
  logic [CW-1:0]         clear_c;
  logic                  clear_en;
  logic                  hs;
  logic [LD_ADDR_W-1:0]  addr_q;

  logic                  ready_n, core_rst_n, done_n, err_n;
  logic                  imem_we_n, dmem_we_n, rf_we_n;
  logic [IMEM_AW-1:0]    imem_addr_n;
  logic [DMEM_AW-1:0]    dmem_addr_n;
  logic [RF_AW-1:0]      rf_addr_n;
  logic [DATA_WIDTH-1:0] imem_wdata_n, dmem_wdata_n, rf_wdata_n;

  assign addr_q    = ld.addr;
  assign hs        = (state == S_LOAD) && ld.valid && ld.ready;
  assign state_dbg = state;

  // cnt always holds the address of the clear write currently on the ports,
  // so the last clear write and the rise of ready land in consecutive cycles.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hold_cnt_n   = hold_cnt;
    ready_n      = 1'b0;
    core_rst_n   = 1'b1;
    done_n       = 1'b0;
    err_n        = err;
    clear_en     = 1'b0;
    clear_c      = '0;
    imem_we_n    = 1'b0;
    imem_addr_n  = '0;
    imem_wdata_n = '0;
    dmem_we_n    = 1'b0;
    dmem_addr_n  = '0;
    dmem_wdata_n = '0;
    rf_we_n      = 1'b0;
    rf_addr_n    = '0;
    rf_wdata_n   = '0;

    unique case (state)
      S_IDLE: begin
        if ((AUTO_START != 0) || start) begin
          state_n  = S_CLEAR;
          cnt_n    = '0;
          clear_en = 1'b1;
          clear_c  = '0;
        end
      end
      S_CLEAR: begin
        if (32'(cnt) == MAXD - 1) begin
          state_n = S_LOAD;
          ready_n = 1'b1;
        end else begin
          cnt_n    = cnt + CW'(1);
          clear_en = 1'b1;
          clear_c  = cnt + CW'(1);
        end
      end
      S_LOAD: begin
        ready_n = 1'b1;
        if (hs) begin
          case (ld.sel)
            2'd0: begin
              if (32'(addr_q) < IMEM_DEPTH) begin
                imem_we_n    = 1'b1;
                imem_addr_n  = addr_q[IMEM_AW-1:0];
                imem_wdata_n = ld.data;
              end else begin
                err_n = 1'b1;
              end
            end
            2'd1: begin
              if (32'(addr_q) < DMEM_DEPTH) begin
                dmem_we_n    = 1'b1;
                dmem_addr_n  = addr_q[DMEM_AW-1:0];
                dmem_wdata_n = ld.data;
              end else begin
                err_n = 1'b1;
              end
            end
            2'd2: begin
              if (32'(addr_q) < RF_DEPTH) begin
                rf_we_n    = 1'b1;
                rf_addr_n  = addr_q[RF_AW-1:0];
                rf_wdata_n = ld.data;
              end else begin
                err_n = 1'b1;
              end
            end
            default: err_n = 1'b1;
          endcase
          // A dropped word still ends the image if it carries last.
          if (ld.last) begin
            state_n    = S_HOLD;
            ready_n    = 1'b0;
            hold_cnt_n = '0;
          end
        end
      end
      S_HOLD: begin
        if (32'(hold_cnt) == RELEASE_CYCLES - 1) begin
          state_n    = S_RUN;
          core_rst_n = 1'b0;
          done_n     = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      S_RUN: begin
        core_rst_n = 1'b0;
        done_n     = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (clear_en) begin
      if (32'(clear_c) < IMEM_DEPTH) begin
        imem_we_n   = 1'b1;
        imem_addr_n = clear_c[IMEM_AW-1:0];
      end
      if (32'(clear_c) < DMEM_DEPTH) begin
        dmem_we_n   = 1'b1;
        dmem_addr_n = clear_c[DMEM_AW-1:0];
      end
      if (32'(clear_c) < RF_DEPTH) begin
        rf_we_n   = 1'b1;
        rf_addr_n = clear_c[RF_AW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hold_cnt   <= '0;
      ld.ready   <= 1'b0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold_cnt   <= hold_cnt_n;
      ld.ready   <= ready_n;
      core_rst   <= core_rst_n;
      done       <= done_n;
      err        <= err_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
      dmem_we    <= dmem_we_n;
      dmem_addr  <= dmem_addr_n;
      dmem_wdata <= dmem_wdata_n;
      rf_we      <= rf_we_n;
      rf_addr    <= rf_addr_n;
      rf_wdata   <= rf_wdata_n;
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: clear sequence, table-driven image loads, dropped words,
// release timing, early valid and reset in the middle of a load.
module tb_mips_boot_loader;

  localparam int DW   = 32;
  localparam int ID   = 512;
  localparam int DD   = 1024;
  localparam int RD   = 32;
  localparam int AW   = 10;
  localparam int RC   = 4;
  localparam int MAXD = 1024;
  localparam int RW   = 1 + 9 + DW + 1 + 10 + DW + 1 + 5 + DW;
  localparam int NV   = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          imem_we, dmem_we, rf_we;
  logic [8:0]    imem_addr;
  logic [9:0]    dmem_addr;
  logic [4:0]    rf_addr;
  logic [DW-1:0] imem_wdata, dmem_wdata, rf_wdata;
  logic          core_rst, done, err;
  logic [2:0]    state_dbg;

  mips_boot_loader_if #(.DATA_WIDTH(DW), .LD_ADDR_W(AW)) ld ();

  mips_boot_loader #(
    .DATA_WIDTH(DW), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .RF_DEPTH(RD),
    .LD_ADDR_W(AW), .RELEASE_CYCLES(RC), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ld(ld),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .core_rst(core_rst), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int r_edge = 0;

  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          wr;
    logic          exp_err;
  } vec_t;

  vec_t tbl[NV];

  // ---------------- check helpers ----------------
  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Ports whose we is low carry don't-care addr/data, so they are zeroed before comparison.
  function automatic logic [RW-1:0] pack_ports(
    input logic iw, input logic [8:0] ia, input logic [DW-1:0] idat,
    input logic dw, input logic [9:0] da, input logic [DW-1:0] ddat,
    input logic rw, input logic [4:0] ra, input logic [DW-1:0] rdat);
    logic [8:0]    ia_m = iw ? ia : 9'd0;
    logic [DW-1:0] id_m = iw ? idat : '0;
    logic [9:0]    da_m = dw ? da : 10'd0;
    logic [DW-1:0] dd_m = dw ? ddat : '0;
    logic [4:0]    ra_m = rw ? ra : 5'd0;
    logic [DW-1:0] rd_m = rw ? rdat : '0;
    return {iw, ia_m, id_m, dw, da_m, dd_m, rw, ra_m, rd_m};
  endfunction

  function automatic logic [RW-1:0] clear_rec(input int c);
    return pack_ports(c < ID, 9'(c), '0, c < DD, 10'(c), '0, c < RD, 5'(c), '0);
  endfunction

  function automatic logic [RW-1:0] load_rec(input logic [1:0] sel, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d);
    case (sel)
      2'd0:    return pack_ports(1'b1, a[8:0], d, 1'b0, '0, '0, 1'b0, '0, '0);
      2'd1:    return pack_ports(1'b0, '0, '0, 1'b1, a[9:0], d, 1'b0, '0, '0);
      default: return pack_ports(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a[4:0], d);
    endcase
  endfunction

  // ---------------- scoreboard: write-port monitor ----------------
  always @(negedge clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] e;
    int ec;
    got = pack_ports(imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
                     rf_we, rf_addr, rf_wdata);
    if ((imem_we | dmem_we | rf_we) === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %0h expected no write at cycle %0d", got, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (got !== e || cyc != ec) begin
          errors++;
          $display("FAIL write_port: got %0h at cycle %0d expected %0h at cycle %0d", got, cyc, e, ec);
        end
      end
    end else if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      e  = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      $display("FAIL missed_write: got none at cycle %0d expected %0h at cycle %0d", cyc, e, ec);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_vec("reset_values",
      160'({core_rst, done, err, ld.ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
            dmem_wdata, rf_we, rf_addr, rf_wdata, state_dbg}),
      160'({1'b1, 129'd0}));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r_edge = cyc + 1;
    for (int c = 0; c < MAXD; c++) begin
      exp_q.push_back(clear_rec(c));
      exp_cyc_q.push_back(r_edge + c);
    end
  endtask

  task automatic wait_clear();
    int bad = 0;
    while (cyc < r_edge + MAXD - 1) begin
      @(negedge clk);
      if (!(core_rst === 1'b1 && done === 1'b0 && ld.ready === 1'b0)) bad++;
    end
    chk_int("clear_core_held_not_ready", bad, 0);
    @(negedge clk);
    chk_bit("ready_after_clear", ld.ready, 1'b1);
    chk_int("clear_writes_outstanding", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic last, input logic wr, output int hs_cyc);
    bit got_ready = 1'b0;
    ld.valid = 1'b1;
    ld.sel   = sel;
    ld.addr  = addr;
    ld.data  = data;
    ld.last  = last;
    hs_cyc   = -1;
    for (int t = 0; t < 3 * MAXD; t++) begin
      @(negedge clk);
      if (ld.ready === 1'b1) begin
        got_ready = 1'b1;
        break;
      end
    end
    checks++;
    if (!got_ready) begin
      errors++;
      $display("FAIL handshake_timeout: got ready=0 expected ready=1 for sel %0d addr %0d", sel, addr);
      ld.valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      hs_cyc = cyc;
      if (wr) begin
        exp_q.push_back(load_rec(sel, addr, data));
        exp_cyc_q.push_back(hs_cyc);
      end
    end
  endtask

  task automatic check_release(input int n);
    @(negedge clk);
    chk_bit("ready_fell_after_last", ld.ready, 1'b0);
    repeat (RC - 1) @(negedge clk);
    chk_bit("core_rst_held_before_release", core_rst, 1'b1);
    chk_bit("done_low_before_release", done, 1'b0);
    @(negedge clk);
    chk_bit("core_rst_released", core_rst, 1'b0);
    chk_bit("done_set", done, 1'b1);
    chk_int("release_cycle", cyc, n + RC);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int hs;
    ld.valid = 1'b0;
    ld.sel   = '0;
    ld.addr  = '0;
    ld.data  = '0;
    ld.last  = 1'b0;

    //          sel   addr     data           last  wr    err
    tbl[0]  = '{2'd0, 10'd1,    32'h2001_0001, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{2'd1, 10'd20,   32'd25,        1'b0, 1'b1, 1'b0};
    tbl[2]  = '{2'd2, 10'd3,    32'd9,         1'b1, 1'b1, 1'b0};
    tbl[3]  = '{2'd0, 10'd511,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{2'd1, 10'd1023, 32'h0000_1234, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{2'd2, 10'd31,   32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2'd2, 10'd0,    32'h0000_0001, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'd0, 10'd600,  32'hBAD0_0001, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{2'd3, 10'd0,    32'hBAD0_0002, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{2'd0, 10'd512,  32'hBAD0_0003, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{2'd2, 10'd32,   32'hBAD0_0004, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2'd1, 10'd7,    $urandom(),    1'b0, 1'b1, 1'b1};
    tbl[12] = '{2'd1, 10'd7,    $urandom(),    1'b0, 1'b1, 1'b1};
    tbl[13] = '{2'd3, 10'd5,    32'h0,         1'b1, 1'b0, 1'b1};

    // Run A: clear, basic three-word image, release, RUN ignores inputs.
    do_reset();
    wait_clear();
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].last, tbl[i].wr, hs);
      chk_bit("err_after_word", err, tbl[i].exp_err);
    end
    ld.valid = 1'b0;
    check_release(hs);
    for (int i = 0; i < 8; i++) begin
      ld.valid = 1'b1;
      ld.sel   = 2'(i % 3);
      ld.addr  = AW'(i);
      ld.data  = $urandom();
      start    = (i % 2 == 0);
      @(posedge clk); #1;
    end
    ld.valid = 1'b0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_vec("run_state", 160'({core_rst, done, ld.ready, state_dbg}), 160'({1'b0, 1'b1, 1'b0, 3'd4}));
    chk_bit("err_clean_run", err, 1'b0);

    // Run B: boundary addresses, dropped words, duplicate writes, last on a dropped word.
    do_reset();
    wait_clear();
    for (int i = 3; i < NV; i++) begin
      send(tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].last, tbl[i].wr, hs);
      chk_bit("err_after_word", err, tbl[i].exp_err);
      if (!tbl[i].last && $urandom_range(0, 2) == 0) begin
        ld.valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ld.valid = 1'b0;
    check_release(hs);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_bit("err_sticky_in_run", err, 1'b1);
    end
    @(posedge clk); #1;

    // Run C: valid held from reset, three handshakes, reset lands on a live handshake.
    ld.valid = 1'b1;
    ld.sel   = 2'd0;
    ld.addr  = 10'd5;
    ld.data  = $urandom();
    ld.last  = 1'b0;
    do_reset();
    send(2'd0, 10'd5, ld.data, 1'b0, 1'b1, hs);
    chk_int("early_valid_first_handshake_edge", hs, r_edge + MAXD + 1);
    send(2'd1, 10'd6, $urandom(), 1'b0, 1'b1, hs);
    send(2'd3, 10'd0, 32'h1234_5678, 1'b0, 1'b0, hs);
    chk_bit("err_before_reset", err, 1'b1);
    ld.sel  = 2'd0;
    ld.addr = 10'd9;
    ld.data = 32'hCAFE_F00D;
    do_reset();
    ld.valid = 1'b0;
    wait_clear();

    repeat (4) @(posedge clk);
    #1;
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no end of test expected end before 500000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog timeout");
  end

endmodule
